// File: rtl/ln_fixed.sv
// ln_fixed: iterative fixed-point natural logarithm.
//
// x = 2^k * m is found by leading-one range reduction, with m in [1,2).
// ln(m) is then built by shift-add pseudo-division, one step per clock,
// using a table of ln(1+2^-i) constants. The result is ln(x) = k*ln2 + ln(m),
// reduced to the output format and saturated.
//
// Optional build macro:
//   LN_FIXED_ROUND_EN - round to nearest, instead of truncating toward -inf,
//                       when the guard bits are dropped.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset
//   enable     in   start request; hold high, drop to abort or release
//   num        in   signed Q(DATA_WIDTH-FIXED_PNT).FIXED_PNT operand x
//   ln_num     out  signed Q(DATA_WIDTH-FIXED_PNT).FIXED_PNT ln(x)
//   data_ready out  result valid, held until enable drops
//   invalid    out  raised with data_ready when x <= 0
module ln_fixed #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned FIXED_PNT  = 8,
    parameter int unsigned GUARD      = 4,
    parameter int unsigned ITERATIONS = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic [DATA_WIDTH-1:0] num,
    output logic [DATA_WIDTH-1:0] ln_num,
    output logic                  data_ready,
    output logic                  invalid
);

    localparam int unsigned F     = FIXED_PNT + GUARD;          // internal fraction bits
    localparam int unsigned MW    = F + 2;                      // mantissa / product width
    localparam int unsigned YW    = F + 1;                      // ln(m) accumulator width
    localparam int unsigned PW    = $clog2(DATA_WIDTH);         // leading-one position width
    localparam int unsigned KW    = $clog2(DATA_WIDTH) + 2;     // signed exponent width
    localparam int unsigned IW    = $clog2(ITERATIONS + 1);     // step counter width
    localparam int unsigned NW    = DATA_WIDTH + F;             // normaliser width
    localparam int unsigned ACC_W = DATA_WIDTH + GUARD + 4;     // combine accumulator width
    localparam int unsigned SC    = 56;                         // constant-generation scale

    // ln(1+2^-i) scaled by 2^SC via the alternating series; powers are plain shifts.
    function automatic longint ln1p_pow2(input int unsigned i);
        longint acc;
        longint pw;
        acc = 0;
        pw  = longint'(1) << (SC - i);
        for (int n = 1; n <= 62; n++) begin
            if ((n % 2) == 1) acc = acc + pw / longint'(n);
            else              acc = acc - pw / longint'(n);
            pw = pw >>> i;
        end
        return acc;
    endfunction

    // ln 2 scaled by 2^SC, from ln2 = sum 1/(n*2^n).
    function automatic longint ln2_scaled();
        longint acc;
        longint pw;
        acc = 0;
        pw  = longint'(1) << (SC - 1);
        for (int n = 1; n <= 62; n++) begin
            acc = acc + pw / longint'(n);
            pw  = pw >>> 1;
        end
        return acc;
    endfunction

    // Round a 2^SC-scaled constant to F fraction bits.
    function automatic logic [YW-1:0] to_frac(input longint v);
        longint r;
        r = (v + (longint'(1) << (SC - F - 1))) >>> (SC - F);
        return YW'(r);
    endfunction

    localparam logic [YW-1:0]          LN2      = to_frac(ln2_scaled());
    localparam logic signed [ACC_W-1:0] LN2_EXT  = ACC_W'(LN2);
    localparam logic [MW-1:0]           ONE      = MW'(1) << F;
    localparam logic signed [ACC_W-1:0] SAT_MAX  =
        {{(ACC_W - DATA_WIDTH + 1){1'b0}}, {(DATA_WIDTH - 1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN  =
        {{(ACC_W - DATA_WIDTH + 1){1'b1}}, {(DATA_WIDTH - 1){1'b0}}};
    localparam logic [DATA_WIDTH-1:0]   OUT_MAX  = {1'b0, {(DATA_WIDTH - 1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0]   OUT_MIN  = {1'b1, {(DATA_WIDTH - 1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_NORM,
        S_ITER,
        S_COMBINE,
        S_DONE
    } state_t;

    // ln(1+2^-i) table, entry 0 unused.
    logic [ITERATIONS:0][YW-1:0] lut;

    assign lut[0] = '0;
    for (genvar g = 1; g <= ITERATIONS; g++) begin : g_lut
        localparam logic [YW-1:0] ENTRY = to_frac(ln1p_pow2(g));
        assign lut[g] = ENTRY;
    end

    state_t                 state, state_nxt;
    logic [DATA_WIDTH-1:0]  x_reg, x_nxt;
    logic [MW-1:0]          m_reg, m_nxt;
    logic [MW-1:0]          p_acc, p_acc_nxt;
    logic [YW-1:0]          y_reg, y_nxt;
    logic signed [KW-1:0]   k_reg, k_nxt;
    logic [IW-1:0]          i_cnt, i_nxt;
    logic [DATA_WIDTH-1:0]  ln_nxt;
    logic                   ready_nxt;
    logic                   invalid_nxt;

    logic                   x_nonpos;
    logic [PW-1:0]          lead_pos;
    logic signed [KW-1:0]   k_norm;
    logic [MW-1:0]          m_norm;
    logic [MW-1:0]          t_step;
    logic                   accept;
    logic signed [ACC_W-1:0] k_ext;
    logic signed [ACC_W-1:0] y_ext;
    logic signed [ACC_W-1:0] r_sum;
    logic signed [ACC_W-1:0] r_red;
    logic [DATA_WIDTH-1:0]  result;

    // Range reduction: leading one of a positive x, exponent and 1.F mantissa.
    always_comb begin
        x_nonpos = x_reg[DATA_WIDTH-1] | (x_reg == '0);
        lead_pos = '0;
        for (int b = 0; b < DATA_WIDTH - 1; b++) begin
            if (x_reg[b]) lead_pos = PW'(b);
        end
        k_norm = signed'(KW'(lead_pos)) - signed'(KW'(FIXED_PNT));
        // Leading one moves from bit p to bit F; low bits may fall off when p > F.
        m_norm = MW'((NW'(x_reg[DATA_WIDTH-2:0]) << F) >> lead_pos);
    end

    // One pseudo-division trial: multiply the running product by (1+2^-i).
    always_comb begin
        t_step = p_acc + (p_acc >> i_cnt);
        accept = (t_step <= m_reg);
    end

    // Final combine: k*ln2 + ln(m), drop guard bits, saturate.
    always_comb begin
        k_ext = ACC_W'(k_reg);
        y_ext = ACC_W'(y_reg);
        r_sum = k_ext * LN2_EXT + y_ext;
`ifdef LN_FIXED_ROUND_EN
        r_sum = r_sum + (ACC_W'(1) << (GUARD - 1));
`endif
        r_red = r_sum >>> GUARD;
        if (r_red > SAT_MAX)      result = OUT_MAX;
        else if (r_red < SAT_MIN) result = OUT_MIN;
        else                      result = r_red[DATA_WIDTH-1:0];
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            x_reg      <= '0;
            m_reg      <= '0;
            p_acc      <= '0;
            y_reg      <= '0;
            k_reg      <= '0;
            i_cnt      <= '0;
            ln_num     <= '0;
            data_ready <= 1'b0;
            invalid    <= 1'b0;
        end else begin
            state      <= state_nxt;
            x_reg      <= x_nxt;
            m_reg      <= m_nxt;
            p_acc      <= p_acc_nxt;
            y_reg      <= y_nxt;
            k_reg      <= k_nxt;
            i_cnt      <= i_nxt;
            ln_num     <= ln_nxt;
            data_ready <= ready_nxt;
            invalid    <= invalid_nxt;
        end
    end

    // Next-state logic; a low enable outside IDLE always returns to IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (enable) state_nxt = S_NORM;
            S_NORM: begin
                if (!enable)       state_nxt = S_IDLE;
                else if (x_nonpos) state_nxt = S_DONE;
                else               state_nxt = S_ITER;
            end
            S_ITER: begin
                if (!enable)                         state_nxt = S_IDLE;
                else if (i_cnt == IW'(ITERATIONS))   state_nxt = S_COMBINE;
            end
            S_COMBINE: begin
                if (!enable) state_nxt = S_IDLE;
                else         state_nxt = S_DONE;
            end
            S_DONE:    if (!enable) state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    // Datapath and output next values; everything holds unless updated.
    always_comb begin
        x_nxt       = x_reg;
        m_nxt       = m_reg;
        p_acc_nxt   = p_acc;
        y_nxt       = y_reg;
        k_nxt       = k_reg;
        i_nxt       = i_cnt;
        ln_nxt      = ln_num;
        ready_nxt   = data_ready;
        invalid_nxt = invalid;
        case (state)
            S_IDLE: begin
                ready_nxt   = 1'b0;
                invalid_nxt = 1'b0;
                if (enable) x_nxt = num;
            end
            S_NORM: begin
                if (enable) begin
                    if (x_nonpos) begin
                        ln_nxt      = OUT_MIN;
                        ready_nxt   = 1'b1;
                        invalid_nxt = 1'b1;
                    end else begin
                        m_nxt     = m_norm;
                        k_nxt     = k_norm;
                        p_acc_nxt = ONE;
                        y_nxt     = '0;
                        i_nxt     = IW'(1);
                    end
                end
            end
            S_ITER: begin
                if (enable) begin
                    if (accept) begin
                        p_acc_nxt = t_step;
                        y_nxt     = y_reg + lut[i_cnt];
                    end
                    i_nxt = i_cnt + IW'(1);
                end
            end
            S_COMBINE: begin
                if (enable) begin
                    ln_nxt      = result;
                    ready_nxt   = 1'b1;
                    invalid_nxt = 1'b0;
                end
            end
            S_DONE: begin
                if (!enable) begin
                    ready_nxt   = 1'b0;
                    invalid_nxt = 1'b0;
                end
            end
            default: begin
                ready_nxt   = 1'b0;
                invalid_nxt = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_ln_fixed.sv
// Bench for ln_fixed: directed operations with a scoreboard of expected
// results, abort/restart and mid-operation reset, and a strided sweep of
// positive operands against a real-valued ln model.
module tb_ln_fixed;

    logic        clk;
    logic        rst;
    logic        enable;
    logic [15:0] num;
    logic [15:0] ln_num;
    logic        data_ready;
    logic        invalid;

    ln_fixed dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .num        (num),
        .ln_num     (ln_num),
        .data_ready (data_ready),
        .invalid    (invalid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [15:0] val;
        logic        inv;
        int          tol;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic chk_tol(input string tag, input logic [15:0] obs, input logic [15:0] expv,
                           input int tol);
        int a;
        int b;
        int d;
        a = int'($signed(obs));
        b = int'($signed(expv));
        d = a - b;
        checks++;
        assert ((d >= -tol) && (d <= tol)) else begin
            errors++;
            $error("FAIL %s: observed 0x%04h expected 0x%04h (+/-%0d)", tag, obs, expv, tol);
        end
    endtask

    function automatic int ref_ln(input int x);
        real v;
        v = $ln(real'(x) / 256.0) * 256.0;
        return $rtoi($floor(v + 0.5));
    endfunction

    // Queue the expected result and raise enable with the operand.
    task automatic start_op(input string tag, input logic [15:0] x, input logic [15:0] expv,
                            input logic inv, input int tol);
        exp_t e;
        e.tag = tag;
        e.val = expv;
        e.inv = inv;
        e.tol = tol;
        e.lat = inv ? 2 : 15;
        sb.push_back(e);
        num    = x;
        enable = 1'b1;
    endtask

    // Wait for data_ready, compare against the scoreboard, hold, then release.
    task automatic finish_op(input int hold);
        int          n;
        exp_t        e;
        logic [15:0] got;
        n = 0;
        do begin
            tick();
            n++;
            if (n == 1) num = 16'($urandom);
        end while ((data_ready !== 1'b1) && (n < 40));
        e   = sb.pop_front();
        got = ln_num;
        chk_eq({e.tag, " latency"}, 32'(n), 32'(e.lat));
        chk_tol({e.tag, " ln_num"}, ln_num, e.val, e.tol);
        chk_eq({e.tag, " invalid"}, 32'(invalid), 32'(e.inv));
        if (hold > 0) begin
            repeat (hold) tick();
            chk_eq({e.tag, " held ready"}, 32'(data_ready), 32'(1));
            chk_eq({e.tag, " held ln_num"}, 32'(ln_num), 32'(got));
        end
        enable = 1'b0;
        tick();
        chk_eq({e.tag, " release ready"}, 32'(data_ready), 32'(0));
        chk_eq({e.tag, " release invalid"}, 32'(invalid), 32'(0));
        chk_eq({e.tag, " release ln_num"}, 32'(ln_num), 32'(got));
    endtask

    initial begin
        bit seen;

        rst    = 1'b1;
        enable = 1'b0;
        num    = '0;
        repeat (3) tick();
        chk_eq("reset ln_num", 32'(ln_num), 32'(0));
        chk_eq("reset ready", 32'(data_ready), 32'(0));
        chk_eq("reset invalid", 32'(invalid), 32'(0));
        rst = 1'b0;
        tick();

        start_op("x=1.0", 16'h0100, 16'h0000, 1'b0, 0);
        finish_op(5);
        start_op("x=e", 16'h02B8, 16'h0100, 1'b0, 1);
        finish_op(1);
        start_op("x=2.0", 16'h0200, 16'h00B1, 1'b0, 1);
        finish_op(1);
        start_op("x=min", 16'h0001, 16'hFA75, 1'b0, 1);
        finish_op(1);
        start_op("x=max", 16'h7FFF, 16'h04DA, 1'b0, 1);
        finish_op(1);
        start_op("x=0", 16'h0000, 16'h8000, 1'b1, 0);
        finish_op(2);
        start_op("x=-1.0", 16'hFF00, 16'h8000, 1'b1, 0);
        finish_op(2);

        // Abort at edge 6; no result may appear and ln_num keeps its old value.
        num    = 16'h0300;
        enable = 1'b1;
        repeat (5) tick();
        enable = 1'b0;
        seen   = 1'b0;
        repeat (20) begin
            tick();
            if (data_ready === 1'b1) seen = 1'b1;
        end
        chk_eq("abort ready", 32'(seen), 32'(0));
        chk_eq("abort ln_num", 32'(ln_num), 32'(16'h8000));

        start_op("restart x=2.0", 16'h0200, 16'h00B1, 1'b0, 1);
        finish_op(1);

        // Strided sweep of positive operands.
        for (int x = 1; x < 32768; x += 97) begin
            start_op($sformatf("sweep 0x%04h", x), 16'(x), 16'(ref_ln(x)), 1'b0, 1);
            finish_op(0);
        end
        start_op("sweep 0x7fff", 16'h7FFF, 16'(ref_ln(32767)), 1'b0, 1);
        finish_op(0);

        // Reset in the middle of the iteration phase.
        num    = 16'h0300;
        enable = 1'b1;
        repeat (6) tick();
        rst = 1'b1;
        tick();
        chk_eq("mid reset ln_num", 32'(ln_num), 32'(0));
        chk_eq("mid reset ready", 32'(data_ready), 32'(0));
        chk_eq("mid reset invalid", 32'(invalid), 32'(0));
        rst    = 1'b0;
        enable = 1'b0;
        tick();

        start_op("after reset x=3.0", 16'h0300, 16'(ref_ln(768)), 1'b0, 1);
        finish_op(1);

        chk_eq("scoreboard empty", 32'(sb.size()), 32'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ln_fixed.md
Name: ln_fixed

Overview:
- Iterative fixed-point natural logarithm; the inverse of the team's Taylor-series exponential block.
- Signed Q(DATA_WIDTH-FIXED_PNT).FIXED_PNT input x; returns ln(x) in the same format.
- Uses the same enable / data_ready start–done handshake as the exponential block.
- Method: shift-add pseudo-division with no multiplier or divider. Leading-one range reduction gives x = 2^k·m, m in [1,2). Then one LUT-driven shift-add step runs per clock.

Parameters:
- DATA_WIDTH, 16: total width of input and output.
- FIXED_PNT, 8: fraction bits of input and output.
- GUARD, 4: extra internal fraction bits. Internal fraction width is F = FIXED_PNT+GUARD.
- ITERATIONS, 12: shift-add steps, i = 1..ITERATIONS. Legal range is 1..F.

Ports:
- clk  in  1: rising-edge clock.
- rst  in  1: reset; synchronous, active-high.
- enable  in  1: start, then hold high. Deassertion aborts or releases.
- num  in  DATA_WIDTH: signed fixed-point operand x.
- ln_num  out  DATA_WIDTH: signed fixed-point ln(x).
- data_ready  out  1: result valid. Held until enable is low.
- invalid  out  1: set with data_ready when x <= 0.

Behaviour:
- Reset (rst=1 at a rising edge): state IDLE; ln_num=0, data_ready=0, invalid=0. Applies mid-operation too; the in-flight computation is discarded.
- States: IDLE, NORM, ITER, COMBINE, DONE.
- IDLE: on an edge with enable=1, capture num into x_reg and go to NORM. num is ignored after capture.
- NORM, when x_reg <= 0: ln_num = most negative value (0x8000 at default width), invalid=1, data_ready=1, go to DONE. Valid 2 edges after the capture edge.
- NORM, when x_reg > 0:
  - Leading-one position p in 0..DATA_WIDTH-2.
  - k = p - FIXED_PNT, signed.
  - m = x_reg normalised to 1.F format, i.e. bit F set.
  - Initialise p_acc = 1.0, y = 0, i = 1, then go to ITER.
- ITER, one step per edge:
  - t = p_acc + (p_acc >> i).
  - If t <= m: p_acc = t and y = y + LUT[i].
  - i = i + 1. After step ITERATIONS, go to COMBINE.
- LUT[i] = ln(1+2^-i) rounded to F fraction bits. LN2 = ln 2 at F bits. Both are elaboration-time constants; no runtime real arithmetic.
- COMBINE:
  - r = k·LN2 + y, in a signed accumulator of width DATA_WIDTH+GUARD+4.
  - Reduce to FIXED_PNT fraction bits: drop the GUARD bits, truncating toward −inf.
  - Saturate to the DATA_WIDTH signed range.
  - Register into ln_num; set data_ready=1, invalid=0; go to DONE.
- Latency for a valid input: data_ready is high after ITERATIONS+3 rising edges, counting the capture edge as edge 1. That is 15 edges at default parameters, independent of x.
- DONE: ln_num, data_ready and invalid hold while enable=1. At the first edge with enable=0, data_ready and invalid clear, state goes to IDLE, and ln_num retains its value.
- Abort: enable=0 at any edge in NORM, ITER or COMBINE returns to IDLE. data_ready stays 0 and ln_num keeps its previous value.
- Restart: enable must be sampled low for at least one edge before a new capture. A continuously high enable never retriggers.
- Accuracy: |error| <= 1 LSB of ln_num for all x > 0 at default parameters.
- Boundary values:
  - x = 1.0 gives exactly 0.
  - Smallest positive x: k = -FIXED_PNT, m = 1.0.
  - Largest positive x: p = DATA_WIDTH-2.

Optional Feature:
- Macro: LN_FIXED_ROUND_EN.
- Defined: COMBINE rounds to nearest by adding 2^(GUARD-1) before dropping the GUARD bits. Saturation is still applied after rounding.
- Undefined: truncation as specified above.
- Latency is identical either way.

Test Plan:
- num=0x0100 (1.0), enable held → data_ready after 15 edges; ln_num=0x0000, invalid=0; hold 5 cycles, then enable low → data_ready=0 next edge, ln_num still 0x0000.
- num=0x02B8 (2.71875) → ln_num=0x0100 ±1 LSB. num=0x0200 (2.0) → ln_num=0x00B1 ±1.
- num=0x0001 → ln_num=0xFA75 ±1 (−5.545). num=0x7FFF → ln_num=0x04DA ±1 (4.852); no saturation.
- num=0x0000, then num=0xFF00 (−1.0) → data_ready and invalid high 2 edges after capture; ln_num=0x8000.
- Abort with enable low at edge 6 → no data_ready. Reassert with num=0x0200 → 0x00B1 at edge 15. Separately, rst=1 mid-ITER → all outputs 0 on the next edge.
- Sweep all positive num against a real-valued ln model → |error| <= 1 LSB. Repeat with LN_FIXED_ROUND_EN defined.
